// File: rtl/player_ship_pkg.sv
// Shared types for the player-ship controller: FSM state encoding and colour layout.
package player_ship_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LEFT  = 3'd1,
    ST_RIGHT = 3'd2,
    ST_HIT   = 3'd3,
    ST_DEAD  = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } color_t;

  function automatic logic is_active(input state_e s);
    return (s == ST_IDLE) || (s == ST_LEFT) || (s == ST_RIGHT);
  endfunction

endpackage

// File: rtl/sat_down_timer.sv
// Loadable down-counter that sticks at zero; flags when a count is still running.
module sat_down_timer #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic               nonzero_o
);

  logic [width_p-1:0] count_q;
  logic [width_p-1:0] count_d;

  // Load has priority; otherwise count down and saturate at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - width_p'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign nonzero_o = (count_q != '0);

endmodule

// File: rtl/player_ship.sv
// Player-ship controller: clamped movement, lives, hit/dead pause with fire-to-resume,
// edge-triggered fire with cooldown and post-resume invulnerability.
module player_ship
  import player_ship_pkg::*;
#(
  parameter int          pos_width_p    = 10,
  parameter int          ship_width_p   = 40,
  parameter int          step_p         = 10,
  parameter int          left_border_p  = 9,
  parameter int          right_border_p = 630,
  parameter int          start_pos_p    = 249,
  parameter int          move_div_p     = 1,
  parameter int          max_lives_p    = 3,
  parameter int          start_lives_p  = 2,
  parameter int          cooldown_p     = 8,
  parameter int          invuln_p       = 16,
  parameter logic [11:0] color_p        = 12'hFFF
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               move_left_i,
  input  logic                               move_right_i,
  input  logic                               shoot_i,
  input  logic                               hit_i,
  input  logic                               add_life_i,
  output logic                               alive_o,
  output logic                               shot_laser_o,
  output logic                               resume_o,
  output logic                               invuln_o,
  output logic [pos_width_p-1:0]             pos_left_o,
  output logic [pos_width_p-1:0]             pos_right_o,
  output logic [pos_width_p-1:0]             gun_pos_o,
  output logic [$clog2(max_lives_p+1)-1:0]   lives_o,
  output logic [STATE_W-1:0]                 state_o,
  output logic [3:0]                         player_red_o,
  output logic [3:0]                         player_green_o,
  output logic [3:0]                         player_blue_o
);

  localparam int LIVES_W = $clog2(max_lives_p + 1);
  localparam int CD_W    = $clog2(cooldown_p + 1);
  localparam int IV_W    = $clog2(invuln_p + 1);
  localparam int DIV_W   = (move_div_p > 1) ? $clog2(move_div_p) : 1;

  localparam logic [pos_width_p-1:0] START_POS   = pos_width_p'(start_pos_p);
  localparam logic [pos_width_p-1:0] LEFT_MIN    = pos_width_p'(left_border_p);
  localparam logic [pos_width_p-1:0] LEFT_THRESH = pos_width_p'(left_border_p + step_p);
  localparam logic [pos_width_p-1:0] RIGHT_PIN   = pos_width_p'(right_border_p - ship_width_p);
  localparam logic [pos_width_p-1:0] STEP        = pos_width_p'(step_p);
  localparam logic [pos_width_p-1:0] SHIP_W      = pos_width_p'(ship_width_p);
  localparam logic [pos_width_p-1:0] GUN_OFS     = pos_width_p'(ship_width_p / 2);
  localparam logic [pos_width_p:0]   RIGHT_REACH = (pos_width_p+1)'(ship_width_p + step_p);
  localparam logic [pos_width_p:0]   RIGHT_LIMIT = (pos_width_p+1)'(right_border_p);
  localparam logic [LIVES_W-1:0]     MAX_LIVES   = LIVES_W'(max_lives_p);
  localparam logic [LIVES_W-1:0]     START_LIVES = LIVES_W'(start_lives_p);
  localparam logic [DIV_W-1:0]       DIV_LAST    = DIV_W'(move_div_p - 1);
  localparam color_t                 COLOR       = color_t'(color_p);

  state_e                 state_q, state_d;
  logic [pos_width_p-1:0] left_q, left_d;
  logic [LIVES_W-1:0]     lives_q, lives_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   shoot_q;
  logic                   shot_q, shot_d;
  logic                   resume_q, resume_d;
  logic                   alive_q, alive_d;

  logic            cd_load_s, iv_load_s, cd_busy_s, iv_busy_s;
  logic [CD_W-1:0] cd_val_s;
  logic            fire_edge_s, eff_hit_s, moving_s, tick_s, add_ok_s, lives_dec_s, lives_load_s;

  assign fire_edge_s = shoot_i & ~shoot_q;
  assign eff_hit_s   = is_active(state_q) & hit_i & ~iv_busy_s;
  assign moving_s    = (state_q == ST_LEFT) || (state_q == ST_RIGHT);
  assign tick_s      = moving_s && (div_q == DIV_LAST);
  assign add_ok_s    = add_life_i && (lives_q < MAX_LIVES);

  // Next-state, position, fire and resume decisions.
  always_comb begin
    state_d      = state_q;
    left_d       = left_q;
    shot_d       = 1'b0;
    resume_d     = 1'b0;
    cd_load_s    = 1'b0;
    cd_val_s     = '0;
    iv_load_s    = 1'b0;
    lives_dec_s  = 1'b0;
    lives_load_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_LEFT, ST_RIGHT: begin
        if (eff_hit_s) begin
          if (lives_q != '0) begin
            lives_dec_s = 1'b1;
            state_d     = ST_HIT;
          end else begin
            state_d = ST_DEAD;
          end
        end else begin
          if (move_left_i && !move_right_i) begin
            state_d = ST_LEFT;
          end else if (move_right_i && !move_left_i) begin
            state_d = ST_RIGHT;
          end else begin
            state_d = ST_IDLE;
          end
          // Steps clamp at the borders rather than overshooting them.
          if (tick_s && (state_q == ST_LEFT)) begin
            left_d = (left_q >= LEFT_THRESH) ? (left_q - STEP) : LEFT_MIN;
          end else if (tick_s && (state_q == ST_RIGHT)) begin
            left_d = (({1'b0, left_q} + RIGHT_REACH) <= RIGHT_LIMIT) ? (left_q + STEP) : RIGHT_PIN;
          end else begin
            left_d = left_q;
          end
          if (fire_edge_s && !cd_busy_s) begin
            shot_d    = 1'b1;
            cd_load_s = 1'b1;
            cd_val_s  = CD_W'(cooldown_p);
          end else begin
            shot_d = 1'b0;
          end
        end
      end
      ST_HIT, ST_DEAD: begin
        if (fire_edge_s) begin
          state_d      = ST_IDLE;
          resume_d     = 1'b1;
          left_d       = START_POS;
          iv_load_s    = 1'b1;
          cd_load_s    = 1'b1;
          cd_val_s     = '0;
          lives_load_s = (state_q == ST_DEAD);
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_DEAD;
    endcase
  end

  // Lives, movement divider and alive flag.
  always_comb begin
    if (lives_load_s) begin
      lives_d = START_LIVES;
    end else begin
      lives_d = lives_q + LIVES_W'(add_ok_s) - LIVES_W'(lives_dec_s);
    end
    if (moving_s) begin
      div_d = tick_s ? '0 : (div_q + DIV_W'(1));
    end else begin
      div_d = '0;
    end
    alive_d = (state_d != ST_DEAD);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      left_q   <= START_POS;
      lives_q  <= START_LIVES;
      div_q    <= '0;
      shoot_q  <= 1'b0;
      shot_q   <= 1'b0;
      resume_q <= 1'b0;
      alive_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      lives_q  <= lives_d;
      div_q    <= div_d;
      shoot_q  <= shoot_i;
      shot_q   <= shot_d;
      resume_q <= resume_d;
      alive_q  <= alive_d;
    end
  end

  sat_down_timer #(.width_p(CD_W)) u_cooldown (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (cd_load_s),
    .load_val_i (cd_val_s),
    .nonzero_o  (cd_busy_s)
  );

  sat_down_timer #(.width_p(IV_W)) u_invuln (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (iv_load_s),
    .load_val_i (IV_W'(invuln_p)),
    .nonzero_o  (iv_busy_s)
  );

  assign alive_o        = alive_q;
  assign shot_laser_o   = shot_q;
  assign resume_o       = resume_q;
  assign invuln_o       = iv_busy_s;
  assign pos_left_o     = left_q;
  assign pos_right_o    = left_q + SHIP_W;
  assign gun_pos_o      = left_q + GUN_OFS;
  assign lives_o        = lives_q;
  assign state_o        = state_q;
  assign player_red_o   = COLOR.red;
  assign player_green_o = COLOR.green;
  assign player_blue_o  = COLOR.blue;

endmodule

// File: tb/tb_player_ship.sv
// Directed plus randomized bench for player_ship against a cycle-level rule model.
module tb_player_ship;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, ml = 1'b0, mr = 1'b0, shoot = 1'b0, hit = 1'b0, add = 1'b0;
  logic alive, shot, resume, invuln;
  logic [9:0] left, right, gun;
  logic [1:0] lives;
  logic [2:0] state;
  logic [3:0] red, green, blue;

  logic reset4 = 1'b1, mr4 = 1'b0;
  logic alive4, shot4, resume4, invuln4;
  logic [9:0] left4, right4, gun4;
  logic [1:0] lives4;
  logic [2:0] state4;
  logic [3:0] red4, green4, blue4;

  player_ship dut (
    .clk_i(clk), .reset_i(reset), .move_left_i(ml), .move_right_i(mr), .shoot_i(shoot),
    .hit_i(hit), .add_life_i(add), .alive_o(alive), .shot_laser_o(shot), .resume_o(resume),
    .invuln_o(invuln), .pos_left_o(left), .pos_right_o(right), .gun_pos_o(gun),
    .lives_o(lives), .state_o(state), .player_red_o(red), .player_green_o(green),
    .player_blue_o(blue)
  );

  player_ship #(.move_div_p(4)) dut4 (
    .clk_i(clk), .reset_i(reset4), .move_left_i(1'b0), .move_right_i(mr4), .shoot_i(1'b0),
    .hit_i(1'b0), .add_life_i(1'b0), .alive_o(alive4), .shot_laser_o(shot4), .resume_o(resume4),
    .invuln_o(invuln4), .pos_left_o(left4), .pos_right_o(right4), .gun_pos_o(gun4),
    .lives_o(lives4), .state_o(state4), .player_red_o(red4), .player_green_o(green4),
    .player_blue_o(blue4)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 left, 2 right, 3 hit, 4 dead.
  int m_state = 0, m_lives = 2, m_left = 249, m_cd = 0, m_inv = 0;
  bit m_prev = 1'b0, m_shot = 1'b0, m_resume = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int ns, nl, nleft, ncd, ninv;
    bit act, fire, eh, dec, reload;
    if (reset) begin
      m_state = 0; m_lives = 2; m_left = 249; m_cd = 0; m_inv = 0;
      m_prev = 1'b0; m_shot = 1'b0; m_resume = 1'b0;
      return;
    end
    act   = (m_state <= 2);
    fire  = shoot && !m_prev;
    eh    = act && hit && (m_inv == 0);
    ns    = m_state;
    nleft = m_left;
    ncd   = (m_cd > 0) ? m_cd - 1 : 0;
    ninv  = (m_inv > 0) ? m_inv - 1 : 0;
    dec = 1'b0; reload = 1'b0; m_shot = 1'b0; m_resume = 1'b0;
    if (act) begin
      if (eh) begin
        if (m_lives > 0) begin dec = 1'b1; ns = 3; end
        else ns = 4;
      end else begin
        ns = (ml && !mr) ? 1 : ((mr && !ml) ? 2 : 0);
        if (m_state == 1) nleft = (m_left - 10 >= 9) ? m_left - 10 : 9;
        if (m_state == 2) nleft = (m_left + 50 <= 630) ? m_left + 10 : 590;
        if (fire && m_cd == 0) begin m_shot = 1'b1; ncd = 8; end
      end
    end else if (fire) begin
      ns = 0; m_resume = 1'b1; nleft = 249; ninv = 16; ncd = 0;
      reload = (m_state == 4);
    end
    nl = m_lives + ((add && m_lives < 3) ? 1 : 0) - (dec ? 1 : 0);
    if (reload) nl = 2;
    m_state = ns; m_lives = nl; m_left = nleft; m_cd = ncd; m_inv = ninv;
    m_prev = shoot;
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_state));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("pos_left", 32'(left), 32'(m_left));
    chk("pos_right", 32'(right), 32'(m_left + 40));
    chk("gun_pos", 32'(gun), 32'(m_left + 20));
    chk("shot_laser", 32'(shot), 32'(m_shot));
    chk("resume", 32'(resume), 32'(m_resume));
    chk("invuln", 32'(invuln), 32'(m_inv > 0));
    chk("alive", 32'(alive), 32'(m_state != 4));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic fire_pulse();
    shoot = 1'b1; cycle();
    shoot = 1'b0; cycle();
  endtask

  int cnt, last_shot, min_gap, exp4;

  initial begin
    // Reset state
    wait_cycles(2);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_lives", 32'(lives), 32'd2);
    chk("reset_left", 32'(left), 32'd249);
    chk("reset_alive", 32'(alive), 32'd1);
    chk("color_red", 32'(red), 32'd15);
    chk("color_blue", 32'(blue), 32'd15);
    reset = 1'b0;

    // Hold left until pinned
    ml = 1'b1;
    wait_cycles(30);
    chk("left_pinned", 32'(left), 32'd9);
    chk("left_pinned_state", 32'(state), 32'd1);
    ml = 1'b0;
    cycle();

    // Divide-by-4 right movement on the second instance
    cycle();
    chk("div4_reset_left", 32'(left4), 32'd249);
    reset4 = 1'b0; mr4 = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      cycle();
      exp4 = 249 + 10 * ((k - 1) / 4);
      if (exp4 > 590) exp4 = 590;
      chk("div4_left", 32'(left4), 32'(exp4));
    end
    chk("div4_pinned_right", 32'(right4), 32'd630);
    chk("div4_state", 32'(state4), 32'd2);

    // Held fire button shoots once
    cnt = 0;
    shoot = 1'b1;
    for (int i = 0; i < 20; i++) begin cycle(); cnt += int'(shot); end
    shoot = 1'b0;
    wait_cycles(10);
    chk("held_fire_count", 32'(cnt), 32'd1);

    // Toggling fire is throttled by cooldown
    cnt = 0; last_shot = -100; min_gap = 1000;
    for (int i = 0; i < 48; i++) begin
      shoot = ((i / 2) % 2 == 0);
      cycle();
      if (shot) begin
        cnt++;
        if (i - last_shot < min_gap) min_gap = i - last_shot;
        last_shot = i;
      end
    end
    shoot = 1'b0;
    cycle();
    chk("toggle_fire_count", 32'(cnt), 32'd4);
    chk("toggle_gap_ge9", 32'(min_gap >= 9), 32'd1);
    wait_cycles(10);

    // Hit with lives, resume, invulnerability window
    hit = 1'b1; cycle(); hit = 1'b0;
    chk("hit_state", 32'(state), 32'd3);
    chk("hit_lives", 32'(lives), 32'd1);
    shoot = 1'b1; cycle(); shoot = 1'b0;
    chk("resume_pulse", 32'(resume), 32'd1);
    chk("resume_left", 32'(left), 32'd249);
    cnt = int'(invuln);
    for (int i = 0; i < 20; i++) begin
      hit = (i == 5);
      cycle();
      cnt += int'(invuln);
    end
    hit = 1'b0;
    chk("invuln_cycles", 32'(cnt), 32'd16);
    chk("invuln_hit_ignored", 32'(lives), 32'd1);

    // Last life lost, death and revival
    hit = 1'b1; cycle(); hit = 1'b0;
    chk("last_hit_lives", 32'(lives), 32'd0);
    fire_pulse();
    wait_cycles(17);
    hit = 1'b1; cycle(); hit = 1'b0;
    chk("dead_state", 32'(state), 32'd4);
    chk("dead_alive", 32'(alive), 32'd0);
    shoot = 1'b1; cycle();
    chk("revive_state", 32'(state), 32'd0);
    chk("revive_lives", 32'(lives), 32'd2);
    chk("revive_alive", 32'(alive), 32'd1);
    shoot = 1'b0; cycle();

    // Lives saturate at max; add with hit nets zero
    add = 1'b1; cycle(); cycle(); add = 1'b0;
    chk("lives_capped", 32'(lives), 32'd3);
    wait_cycles(17);
    hit = 1'b1; cycle(); hit = 1'b0;
    fire_pulse();
    wait_cycles(17);
    hit = 1'b1; cycle(); hit = 1'b0;
    fire_pulse();
    wait_cycles(17);
    chk("pre_add_hit_lives", 32'(lives), 32'd1);
    hit = 1'b1; add = 1'b1; cycle(); hit = 1'b0; add = 1'b0;
    chk("add_hit_lives", 32'(lives), 32'd1);
    chk("add_hit_state", 32'(state), 32'd3);
    fire_pulse();

    // Reset overrides simultaneous events
    wait_cycles(17);
    ml = 1'b1; wait_cycles(3);
    reset = 1'b1; hit = 1'b1; shoot = 1'b1; cycle();
    reset = 1'b0; hit = 1'b0; shoot = 1'b0; ml = 1'b0;
    chk("reset_override_state", 32'(state), 32'd0);
    chk("reset_override_left", 32'(left), 32'd249);
    chk("reset_override_shot", 32'(shot), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      ml    = $urandom_range(0, 1) == 1;
      mr    = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) shoot = ~shoot;
      hit   = ($urandom_range(0, 15) == 0);
      add   = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_ship.md
# player_ship

Parametrised player-ship controller for the space-invaders datapath: a next-generation replacement for the fixed-geometry player block. It tracks horizontal position with clamped stepping and a configurable movement rate, a saturating lives counter, and a hit/dead pause flow resumed by the fire button. It adds rising-edge fire with cooldown and post-resume invulnerability. It sits between the button debouncers and the bullet/collision and VGA draw logic.

## Interface
- `pos_width_p`, 10, width of all position buses
- `ship_width_p`, 40, ship width in pixels
- `step_p`, 10, pixels moved per movement tick
- `left_border_p`, 9, minimum legal `pos_left_o`
- `right_border_p`, 630, maximum legal `pos_right_o`
- `start_pos_p`, 249, `pos_left_o` after reset or resume
- `move_div_p`, 1, clock cycles per movement tick (≥1)
- `max_lives_p`, 3; `start_lives_p`, 2, lives cap and initial lives
- `cooldown_p`, 8, cycles after a shot during which fire is ignored
- `invuln_p`, 16, cycles after resume during which `hit_i` is ignored
- `color_p`, 12'hFFF, {R,G,B} 4 bits each
- `clk_i` in 1: clock. Single clock domain.
- `reset_i` in 1: reset. Synchronous, active-high.
- `move_left_i` / `move_right_i` / `shoot_i` in 1: debounced buttons
- `hit_i` in 1: enemy bullet collision
- `add_life_i` in 1: single-cycle pulse, level beaten
- `alive_o` out 1: high unless in DEAD
- `shot_laser_o` out 1: one-cycle spawn-bullet pulse
- `resume_o` out 1: one-cycle pulse on leaving HIT or DEAD
- `invuln_o` out 1: invulnerability timer nonzero
- `pos_left_o` / `pos_right_o` / `gun_pos_o` out `pos_width_p`: left edge, left+`ship_width_p`, left+`ship_width_p`/2
- `lives_o` out `$clog2(max_lives_p+1)`: current lives
- `state_o` out 3: present state for debug
- `player_red_o` / `player_green_o` / `player_blue_o` out 4: slices of `color_p`

## Operation
- States: IDLE, LEFT, RIGHT, HIT, DEAD. Encodings 0–4. Any other encoding goes to DEAD.
- Direction in IDLE/LEFT/RIGHT: only `move_left_i` high → LEFT; only `move_right_i` high → RIGHT; both or neither → IDLE.
- Effective hit = `hit_i` & ~`invuln_o`, sampled in IDLE/LEFT/RIGHT. It has priority over movement and fire.
  - Lives >0: decrement lives, go to HIT.
  - Lives =0: go to DEAD.
- HIT/DEAD: position frozen; movement, fire and hits ignored.
  - Fire edge → IDLE, `resume_o` pulse, position := `start_pos_p`, invulnerability := `invuln_p`, cooldown := 0.
  - Leaving DEAD also loads lives := `start_lives_p`.
- Movement tick: divider counts 0..`move_div_p`-1 while in LEFT/RIGHT and ticks on wrap. The divider clears in any other state.
- Left step: new = left−`step_p` if left ≥ `left_border_p`+`step_p`, else `left_border_p`.
- Right step: new = left+`step_p` if left+`ship_width_p`+`step_p` ≤ `right_border_p`, else `right_border_p`−`ship_width_p`. Position never leaves the borders, and the FSM stays in LEFT/RIGHT when pinned.
- Fire edge = `shoot_i` & ~shoot_q, where shoot_q is `shoot_i` registered.
  - In IDLE/LEFT/RIGHT with cooldown =0 and no effective hit: `shot_laser_o` pulses and cooldown := `cooldown_p`.
  - A held button fires once.
- Lives: next = lives + (`add_life_i` & lives<`max_lives_p`) − (decrement). Simultaneous add and hit nets zero. Lives never wrap.
- Cooldown and invulnerability timers decrement to 0 and saturate there.

## Timing
- All state, position, lives, timer and pulse outputs are registered. Position and gun outputs are combinational adds off the registered left edge.
- Reset values:
  - State IDLE; lives `start_lives_p`; left `start_pos_p`.
  - Cooldown 0; invulnerability 0; shoot_q 0; divider 0.
  - `alive_o`=1; `shot_laser_o`=`resume_o`=`invuln_o`=0.
- Fire-edge cycle N → `shot_laser_o` high in cycle N+1 only.
- Hit sampled in N → `state_o`/`lives_o` updated in N+1.
- With `move_div_p`=1, position changes in the cycle after entering LEFT/RIGHT and every cycle after that.
- Reset mid-operation overrides every event in that cycle.

## Structure
- `player_ship_pkg`: state enum, state width, `color_t`.
- Sub-module `sat_down_timer` (load, decrement, saturate at 0, `nonzero_o`), instantiated for cooldown and for invulnerability.

## Test plan
- Reset; hold `move_left_i` with defaults → left steps 249,239,…,19,9, then holds at 9 with state LEFT.
- `move_div_p`=4, hold `move_right_i` → +10 every 4 cycles; pins at left=590, right=630.
- Hold `shoot_i` 20 cycles → exactly one `shot_laser_o`. Toggle every 2 cycles → pulses spaced ≥9 cycles.
- Hit at lives=2 → HIT, lives=1. Fire → `resume_o`, left=249, `invuln_o` high 16 cycles; a hit during this window is ignored.
- Hit at lives=0 → DEAD, `alive_o`=0. Fire → IDLE, lives=2, `alive_o`=1.
- `add_life_i` at lives=3 → stays 3. `add_life_i` with hit at lives=1 → lives 1, state HIT.
